// File: rtl/i2c_slave.sv
// I2C target: synchronizes SCL/SDA, detects START/STOP, matches a 7-bit address
// and receives or transmits bytes MSB first. SDA is open-drain; SCL is never driven.
module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h01
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   inout  wire        sda,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic       busy,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      ADDR      = 4'd1,
      ADDR_ACK  = 4'd2,
      WRITE     = 4'd3,
      WRITE_ACK = 4'd4,
      READ      = 4'd5,
      READ_ACK  = 4'd6,
      IGNORE    = 4'd7
   } state_e;

   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       done_q, done_d;
   logic       ack_q, ack_d;
   logic       sda_oe_q, sda_oe_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       tx_req_q, tx_req_d;
   logic       busy_q, busy_d;
   // [0] first sync stage, [1] synced value, [2] previous synced value
   logic [2:0] scl_sync_q, scl_sync_d;
   logic [2:0] sda_sync_q, sda_sync_d;

   logic scl_s, sda_s;
   logic scl_rise, scl_fall, sda_rise, sda_fall;
   logic start, stop;

   assign scl_s    = scl_sync_q[1];
   assign sda_s    = sda_sync_q[1];
   assign scl_rise = scl_sync_q[1] & ~scl_sync_q[2];
   assign scl_fall = ~scl_sync_q[1] & scl_sync_q[2];
   assign sda_rise = sda_sync_q[1] & ~sda_sync_q[2];
   assign sda_fall = ~sda_sync_q[1] & sda_sync_q[2];
   assign start    = sda_fall & scl_s;
   assign stop     = sda_rise & scl_s;

   assign sda      = sda_oe_q ? 1'b0 : 1'bz;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign tx_req   = tx_req_q;
   assign busy     = busy_q;
   assign state    = state_q;

   always_comb begin
      scl_sync_d = {scl_sync_q[1:0], scl};
      sda_sync_d = {sda_sync_q[1:0], sda};
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      done_d     = done_q;
      ack_d      = ack_q;
      sda_oe_d   = sda_oe_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_req_d   = 1'b0;
      busy_d     = busy_q;
      if (start) begin
         state_d  = ADDR;
         cnt_d    = 3'd0;
         done_d   = 1'b0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (stop) begin
         state_d  = IDLE;
         cnt_d    = 3'd0;
         done_d   = 1'b0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         unique case (state_q)
            ADDR, WRITE: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], sda_s};
                  cnt_d   = cnt_q + 3'd1;
                  done_d  = (cnt_q == 3'd7);
               end else if (scl_fall && done_q) begin
                  done_d = 1'b0;
                  if (state_q == WRITE) begin
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
                     sda_oe_d   = 1'b1;
                     state_d    = WRITE_ACK;
                  end else if (shift_q[7:1] == SLAVE_ADDR) begin
                     sda_oe_d = 1'b1;
                     busy_d   = 1'b1;
                     state_d  = ADDR_ACK;
                  end else begin
                     state_d = IGNORE;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  cnt_d = 3'd0;
                  if (!shift_q[0]) begin
                     sda_oe_d = 1'b0;
                     state_d  = WRITE;
                  end else begin
                     shift_d  = tx_data;
                     tx_req_d = 1'b1;
                     sda_oe_d = ~tx_data[7];
                     state_d  = READ;
                  end
               end
            end
            WRITE_ACK: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  cnt_d    = 3'd0;
                  state_d  = WRITE;
               end
            end
            READ: begin
               if (scl_fall) begin
                  if (cnt_q == 3'd7) begin
                     sda_oe_d = 1'b0;
                     cnt_d    = 3'd0;
                     state_d  = READ_ACK;
                  end else begin
                     cnt_d    = cnt_q + 3'd1;
                     shift_d  = {shift_q[6:0], 1'b0};
                     sda_oe_d = ~shift_q[6];
                  end
               end
            end
            READ_ACK: begin
               if (scl_rise) begin
                  ack_d = sda_s;
               end else if (scl_fall) begin
                  if (!ack_q) begin
                     shift_d  = tx_data;
                     tx_req_d = 1'b1;
                     sda_oe_d = ~tx_data[7];
                     cnt_d    = 3'd0;
                     state_d  = READ;
                  end else begin
                     sda_oe_d = 1'b0;
                     busy_d   = 1'b0;
                     state_d  = IGNORE;
                  end
               end
            end
            IDLE, IGNORE: ;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd0;
         shift_q    <= 8'h00;
         done_q     <= 1'b0;
         ack_q      <= 1'b0;
         sda_oe_q   <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
         busy_q     <= 1'b0;
         scl_sync_q <= 3'b111;
         sda_sync_q <= 3'b111;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         done_q     <= done_d;
         ack_q      <= ack_d;
         sda_oe_q   <= sda_oe_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_req_q   <= tx_req_d;
         busy_q     <= busy_d;
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged initiator, a table of transactions, hand-written
// corner sequences and randomized transactions checked against a transaction model.
module tb_i2c_slave;

   localparam int Q = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1;
   logic       m_low = 1'b0;
   wire        sda_w;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data = 8'h00;
   logic       tx_req;
   logic       busy;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;
   int rx_cnt = 0;
   int tx_cnt = 0;
   logic       rx_valid_p = 1'b0;
   logic       tx_req_p = 1'b0;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];

   assign sda_w = m_low ? 1'b0 : 1'bz;
   pullup (sda_w);

   i2c_slave #(.SLAVE_ADDR(7'h01)) dut (
      .clk      (clk),
      .rst      (rst),
      .scl      (scl),
      .sda      (sda_w),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_req   (tx_req),
      .busy     (busy),
      .state    (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         rx_q.push_back(rx_data);
         rx_cnt <= rx_cnt + 1;
         check("rx_valid_width", rx_valid_p, 1'b0);
         check("rx_tx_overlap", tx_req, 1'b0);
      end
      if (tx_req === 1'b1) begin
         tx_cnt <= tx_cnt + 1;
         check("tx_req_width", tx_req_p, 1'b0);
      end
      rx_valid_p <= rx_valid;
      tx_req_p   <= tx_req;
   end

   initial begin
      #2ms;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   task automatic hold();
      repeat (Q) @(negedge clk);
   endtask

   task automatic m_start();
      m_low = 1'b0; hold();
      scl = 1'b1;   hold();
      m_low = 1'b1; hold();
      scl = 1'b0;   hold();
   endtask

   task automatic m_stop();
      m_low = 1'b1; hold();
      scl = 1'b1;   hold();
      m_low = 1'b0; hold();
   endtask

   task automatic m_bit(input logic b, output logic s);
      m_low = ~b; hold();
      scl = 1'b1; hold();
      s = sda_w;  hold();
      scl = 1'b0; hold();
   endtask

   task automatic m_byte_w(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) m_bit(d[i], s);
      m_bit(1'b1, ack);
   endtask

   task automatic m_byte_r(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         m_bit(1'b1, s);
         d[i] = s;
      end
      m_bit(mack, s);
   endtask

   typedef struct {
      logic [6:0] addr;
      logic       rw;
      logic [7:0] b0;
      logic [7:0] b1;
      logic       exp_ack;
      logic [3:0] exp_state;
      logic       exp_busy;
      int         exp_rx;
      int         exp_tx;
      logic [7:0] exp_d0;
      logic [7:0] exp_d1;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic       a, k0, k1, m, rw;
      logic [7:0] d0, d1, got;
      logic [6:0] ad;
      logic [7:0] bytes[3];
      int         rx0, tx0, n;

      vecs[0] = '{7'h01, 1'b0, 8'hA5, 8'h3C, 1'b0, 4'd3, 1'b1, 2, 0, 8'h00, 8'h00};
      vecs[1] = '{7'h03, 1'b0, 8'hFF, 8'h00, 1'b1, 4'd7, 1'b0, 0, 0, 8'h00, 8'h00};
      vecs[2] = '{7'h01, 1'b1, 8'h3C, 8'hC3, 1'b0, 4'd7, 1'b0, 0, 2, 8'h3C, 8'hC3};
      vecs[3] = '{7'h7F, 1'b1, 8'h55, 8'hAA, 1'b1, 4'd7, 1'b0, 0, 0, 8'hFF, 8'hFF};
      vecs[4] = '{7'h41, 1'b0, 8'h12, 8'h34, 1'b1, 4'd7, 1'b0, 0, 0, 8'h00, 8'h00};
      vecs[5] = '{7'h01, 1'b1, 8'h80, 8'h01, 1'b0, 4'd7, 1'b0, 0, 2, 8'h80, 8'h01};
      vecs[6] = '{7'h00, 1'b0, 8'h02, 8'h03, 1'b1, 4'd7, 1'b0, 0, 0, 8'h00, 8'h00};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset state", state, 4'd0);
      check("reset busy", busy, 1'b0);
      check("reset rx_valid", rx_valid, 1'b0);
      check("reset tx_req", tx_req, 1'b0);
      check("reset rx_data", rx_data, 8'h00);
      check("reset sda", sda_w, 1'b1);

      for (int v = 0; v < 7; v++) begin
         rx_q.delete();
         rx0 = rx_cnt;
         tx0 = tx_cnt;
         tx_data = vecs[v].b0;
         m_start();
         m_byte_w({vecs[v].addr, vecs[v].rw}, a);
         check($sformatf("vec%0d addr_ack", v), a, vecs[v].exp_ack);
         if (vecs[v].rw) begin
            tx_data = vecs[v].b1;
            m_byte_r(1'b0, d0);
            m_byte_r(1'b1, d1);
            check($sformatf("vec%0d rd0", v), d0, vecs[v].exp_d0);
            check($sformatf("vec%0d rd1", v), d1, vecs[v].exp_d1);
         end else begin
            m_byte_w(vecs[v].b0, k0);
            m_byte_w(vecs[v].b1, k1);
            check($sformatf("vec%0d ack0", v), k0, vecs[v].exp_ack);
            check($sformatf("vec%0d ack1", v), k1, vecs[v].exp_ack);
         end
         check($sformatf("vec%0d state", v), state, vecs[v].exp_state);
         check($sformatf("vec%0d busy", v), busy, vecs[v].exp_busy);
         check($sformatf("vec%0d rx_cnt", v), rx_cnt - rx0, vecs[v].exp_rx);
         check($sformatf("vec%0d tx_cnt", v), tx_cnt - tx0, vecs[v].exp_tx);
         if (rx_q.size() == 2) begin
            check($sformatf("vec%0d rx0", v), rx_q[0], vecs[v].b0);
            check($sformatf("vec%0d rx1", v), rx_q[1], vecs[v].b1);
         end
         m_stop();
         check($sformatf("vec%0d stop state", v), state, 4'd0);
         check($sformatf("vec%0d stop busy", v), busy, 1'b0);
      end

      // write of one byte
      rx0 = rx_cnt;
      m_start();
      m_byte_w(8'h02, a);
      check("t1 addr ack", a, 1'b0);
      check("t1 busy", busy, 1'b1);
      m_byte_w(8'hA5, k0);
      check("t1 data ack", k0, 1'b0);
      check("t1 rx_cnt", rx_cnt - rx0, 1);
      check("t1 rx_data", rx_data, 8'hA5);
      m_stop();
      check("t1 busy stop", busy, 1'b0);
      check("t1 state", state, 4'd0);

      // address miss
      rx0 = rx_cnt;
      m_start();
      m_byte_w(8'h06, a);
      check("t2 addr ack", a, 1'b1);
      m_byte_w(8'hFF, k0);
      check("t2 data ack", k0, 1'b1);
      check("t2 state", state, 4'd7);
      check("t2 rx_cnt", rx_cnt - rx0, 0);
      m_stop();
      check("t2 stop state", state, 4'd0);

      // two-byte read, ACK then NACK
      tx0 = tx_cnt;
      tx_data = 8'h3C;
      m_start();
      m_byte_w(8'h03, a);
      check("t3 addr ack", a, 1'b0);
      m_byte_r(1'b0, d0);
      m_byte_r(1'b1, d1);
      check("t3 byte1", d0, 8'h3C);
      check("t3 byte2", d1, 8'h3C);
      check("t3 tx_req", tx_cnt - tx0, 2);
      check("t3 state", state, 4'd7);
      check("t3 busy", busy, 1'b0);
      m_stop();

      // repeated START from write into read
      tx_data = 8'h96;
      m_start();
      m_byte_w(8'h02, a);
      m_byte_w(8'h11, k0);
      check("t4 data ack", k0, 1'b0);
      m_start();
      m_byte_w(8'h03, a);
      check("t4 second addr ack", a, 1'b0);
      m_byte_r(1'b1, d0);
      check("t4 read byte", d0, 8'h96);
      m_stop();
      check("t4 rx_data", rx_data, 8'h11);
      check("t4 state", state, 4'd0);

      // reset while the target holds SDA low
      tx_data = 8'h00;
      m_start();
      m_byte_w(8'h03, a);
      check("t5 target drives 0", sda_w, 1'b0);
      check("t5 state read", state, 4'd5);
      rst = 1'b1;
      @(negedge clk);
      check("t5 sda released", sda_w, 1'b1);
      check("t5 state", state, 4'd0);
      check("t5 busy", busy, 1'b0);
      check("t5 rx_data", rx_data, 8'h00);
      check("t5 rx_valid", rx_valid, 1'b0);
      check("t5 tx_req", tx_req, 1'b0);
      rst = 1'b0;
      scl = 1'b1;
      hold();
      m_start();
      m_byte_w(8'h02, a);
      m_byte_w(8'h77, k0);
      check("t5 after ack", k0, 1'b0);
      check("t5 after rx", rx_data, 8'h77);
      m_stop();

      // STOP in the middle of a data byte
      rx0 = rx_cnt;
      m_start();
      m_byte_w(8'h02, a);
      m_bit(1'b1, k0);
      m_bit(1'b0, k0);
      m_bit(1'b1, k0);
      m_bit(1'b1, k0);
      m_stop();
      check("t6 rx_cnt", rx_cnt - rx0, 0);
      check("t6 state", state, 4'd0);
      check("t6 sda", sda_w, 1'b1);
      check("t6 busy", busy, 1'b0);

      // randomized transactions against a transaction-level model
      for (int t = 0; t < 20; t++) begin
         ad = ($urandom_range(0, 1) == 1) ? 7'h01 : 7'($urandom_range(0, 127));
         rw = 1'($urandom_range(0, 1));
         n  = $urandom_range(1, 3);
         for (int j = 0; j < 3; j++) bytes[j] = 8'($urandom_range(0, 255));
         m  = (ad == 7'h01);
         rx_q.delete();
         exp_q.delete();
         tx0 = tx_cnt;
         tx_data = bytes[0];
         m_start();
         m_byte_w({ad, rw}, a);
         check($sformatf("rnd%0d addr ack", t), a, !m);
         for (int j = 0; j < n; j++) begin
            if (!rw) begin
               m_byte_w(bytes[j], k0);
               check($sformatf("rnd%0d wack%0d", t, j), k0, !m);
               if (m) exp_q.push_back(bytes[j]);
            end else begin
               if (j + 1 < n) tx_data = bytes[j + 1];
               m_byte_r(j == n - 1, got);
               check($sformatf("rnd%0d rd%0d", t, j), got, m ? bytes[j] : 8'hFF);
            end
         end
         check($sformatf("rnd%0d busy", t), busy, m && !rw);
         check($sformatf("rnd%0d tx_cnt", t), tx_cnt - tx0, (m && rw) ? n : 0);
         check($sformatf("rnd%0d rx_n", t), rx_q.size(), exp_q.size());
         for (int j = 0; j < rx_q.size() && j < exp_q.size(); j++)
            check($sformatf("rnd%0d rx%0d", t, j), rx_q[j], exp_q[j]);
         m_stop();
         check($sformatf("rnd%0d stop state", t), state, 4'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
